// File: rtl/axis_byte_packer.sv
// Byte-to-word AXI-Stream up-converter: packs WIDTH_BYTES input bytes, first byte MSB,
// into one output word held in a registered output slice with full-throughput handoff.
module axis_byte_packer #(
  parameter int unsigned WIDTH_BYTES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [8*WIDTH_BYTES-1:0] m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);

  localparam int unsigned CNT_W = (WIDTH_BYTES > 1) ? $clog2(WIDTH_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH_BYTES - 1);

  logic [CNT_W-1:0]         r_cnt;
  logic                     w_last;
  logic                     w_accept;
  logic [8*WIDTH_BYTES-1:0] w_word;

  assign w_last        = (r_cnt == LAST);
  // Only the final byte needs the output register; earlier bytes always land in the accumulator.
  assign s_axis_tready = !rst && (!w_last || !m_axis_tvalid || m_axis_tready);
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  generate
    if (WIDTH_BYTES > 1) begin : g_acc
      localparam int unsigned ACC_W = 8 * (WIDTH_BYTES - 1);
      logic [ACC_W-1:0] r_acc;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_acc <= '0;
        end else if (w_accept && !w_last) begin
          r_acc <= ACC_W'({r_acc, s_axis_tdata});
        end
      end

      assign w_word = {r_acc, s_axis_tdata};
    end else begin : g_no_acc
      assign w_word = s_axis_tdata;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (w_accept && w_last) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= w_word;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_byte_packer.sv
// Self-checking bench for axis_byte_packer at widths 1..4: directed scenarios plus
// randomized traffic compared against a queue-based packing model.
module tb_axis_byte_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;

  logic        rst1, sv1, sr1, mv1, mr1;
  logic [7:0]  sd1, md1;
  logic        rst2, sv2, sr2, mv2, mr2;
  logic [7:0]  sd2;
  logic [15:0] md2;
  logic        rst3, sv3, sr3, mv3, mr3;
  logic [7:0]  sd3;
  logic [23:0] md3;
  logic        rst4, sv4, sr4, mv4, mr4;
  logic [7:0]  sd4;
  logic [31:0] md4;

  axis_byte_packer #(.WIDTH_BYTES(1)) u_w1 (
    .clk(clk), .rst(rst1), .s_axis_tdata(sd1), .s_axis_tvalid(sv1), .s_axis_tready(sr1),
    .m_axis_tdata(md1), .m_axis_tvalid(mv1), .m_axis_tready(mr1));
  axis_byte_packer #(.WIDTH_BYTES(2)) u_w2 (
    .clk(clk), .rst(rst2), .s_axis_tdata(sd2), .s_axis_tvalid(sv2), .s_axis_tready(sr2),
    .m_axis_tdata(md2), .m_axis_tvalid(mv2), .m_axis_tready(mr2));
  axis_byte_packer #(.WIDTH_BYTES(3)) u_w3 (
    .clk(clk), .rst(rst3), .s_axis_tdata(sd3), .s_axis_tvalid(sv3), .s_axis_tready(sr3),
    .m_axis_tdata(md3), .m_axis_tvalid(mv3), .m_axis_tready(mr3));
  axis_byte_packer #(.WIDTH_BYTES(4)) u_w4 (
    .clk(clk), .rst(rst4), .s_axis_tdata(sd4), .s_axis_tvalid(sv4), .s_axis_tready(sr4),
    .m_axis_tdata(md4), .m_axis_tvalid(mv4), .m_axis_tready(mr4));

  // Handshake monitors: accepted input bytes, accepted output words, hold-while-stalled violations.
  logic [7:0]  in1[$], out1[$], in3[$];
  logic [15:0] out2[$];
  logic [23:0] out3[$];
  int unsigned stab1 = 0, stab3 = 0;
  logic        p_v1 = 1'b0, p_r1 = 1'b0, p_rst1 = 1'b1;
  logic [7:0]  p_d1 = '0;
  logic        p_v3 = 1'b0, p_r3 = 1'b0, p_rst3 = 1'b1;
  logic [23:0] p_d3 = '0;

  always @(posedge clk) begin
    if (sv1 && sr1) in1.push_back(sd1);
    if (mv1 && mr1) out1.push_back(md1);
    if (p_v1 && !p_r1 && !p_rst1 && (mv1 !== 1'b1 || md1 !== p_d1)) stab1++;
    p_v1 = mv1; p_r1 = mr1; p_rst1 = rst1; p_d1 = md1;
  end

  always @(posedge clk) begin
    if (sv3 && sr3) in3.push_back(sd3);
    if (mv3 && mr3) out3.push_back(md3);
    if (p_v3 && !p_r3 && !p_rst3 && (mv3 !== 1'b1 || md3 !== p_d3)) stab3++;
    p_v3 = mv3; p_r3 = mr3; p_rst3 = rst3; p_d3 = md3;
  end

  always @(posedge clk) begin
    if (mv2 && mr2) out2.push_back(md2);
  end

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst1 = 1; rst2 = 1; rst3 = 1; rst4 = 1;
    sv1 = 1; sv2 = 1; sv3 = 1; sv4 = 1;
    sd1 = 8'($urandom); sd2 = 8'($urandom); sd3 = 8'($urandom); sd4 = 8'($urandom);
    mr1 = 0; mr2 = 0; mr3 = 0; mr4 = 0;
    step; step;
    n_chk++; if (mv1 !== 1'b0 || md1 !== 8'h00) $display("FAIL reset_w1: valid=%b data=%h want 0/00", mv1, md1); else n_pass++;
    n_chk++; if (mv2 !== 1'b0 || md2 !== 16'h0) $display("FAIL reset_w2: valid=%b data=%h want 0/0000", mv2, md2); else n_pass++;
    n_chk++; if (mv3 !== 1'b0 || md3 !== 24'h0) $display("FAIL reset_w3: valid=%b data=%h want 0/000000", mv3, md3); else n_pass++;
    n_chk++; if (mv4 !== 1'b0 || md4 !== 32'h0) $display("FAIL reset_w4: valid=%b data=%h want 0/00000000", mv4, md4); else n_pass++;
    n_chk++; if ({sr1, sr2, sr3, sr4} !== 4'b0000) $display("FAIL reset_tready: got %b want 0000", {sr1, sr2, sr3, sr4}); else n_pass++;
    sv1 = 0; sv2 = 0; sv3 = 0; sv4 = 0;
    rst1 = 0; rst2 = 0; rst3 = 0; rst4 = 0;
    #1;
    n_chk++; if ({sr1, sr2, sr3, sr4} !== 4'b1111) $display("FAIL reset_release_tready: got %b want 1111", {sr1, sr2, sr3, sr4}); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [7:0] b[3];
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
    mr3 = 1;
    for (int i = 0; i < 3; i++) begin
      sv3 = 1; sd3 = b[i];
      step;
      if (i < 2) begin
        n_chk++; if (mv3 !== 1'b0) $display("FAIL basic_early_valid[%0d]: got %b want 0", i, mv3); else n_pass++;
      end
    end
    sv3 = 0; sd3 = 8'hFF;
    n_chk++; if (mv3 !== 1'b1 || md3 !== 24'h112233) $display("FAIL basic_word: valid=%b data=%h want 1/112233", mv3, md3); else n_pass++;
    step;
    n_chk++; if (mv3 !== 1'b0) $display("FAIL basic_one_cycle: valid=%b want 0", mv3); else n_pass++;
  endtask

  task automatic test_throughput;
    logic [23:0] exp;
    mr3 = 1;
    for (int unsigned i = 0; i < 9; i++) begin
      sv3 = 1; sd3 = 8'(i + 1);
      n_chk++; if (sr3 !== 1'b1) $display("FAIL thru_tready[%0d]: got %b want 1", i, sr3); else n_pass++;
      step;
      if (i % 3 == 2) begin
        exp = {8'(i - 1), 8'(i), 8'(i + 1)};
        n_chk++; if (mv3 !== 1'b1 || md3 !== exp) $display("FAIL thru_word[%0d]: valid=%b data=%h want 1/%h", i, mv3, md3, exp); else n_pass++;
      end else begin
        n_chk++; if (mv3 !== 1'b0) $display("FAIL thru_gap[%0d]: valid=%b want 0", i, mv3); else n_pass++;
      end
    end
    sv3 = 0;
    step;
  endtask

  task automatic test_backpressure;
    out2.delete();
    mr2 = 0;
    sv2 = 1; sd2 = 8'hAA; step;
    sd2 = 8'hBB; step;
    n_chk++; if (mv2 !== 1'b1 || md2 !== 16'hAABB) $display("FAIL bp_first: valid=%b data=%h want 1/aabb", mv2, md2); else n_pass++;
    sd2 = 8'hCC;
    n_chk++; if (sr2 !== 1'b1) $display("FAIL bp_cc_tready: got %b want 1", sr2); else n_pass++;
    step;
    n_chk++; if (mv2 !== 1'b1 || md2 !== 16'hAABB) $display("FAIL bp_hold1: valid=%b data=%h want 1/aabb", mv2, md2); else n_pass++;
    sd2 = 8'hDD;
    n_chk++; if (sr2 !== 1'b0) $display("FAIL bp_dd_stall: got %b want 0", sr2); else n_pass++;
    step;
    n_chk++; if (sr2 !== 1'b0 || mv2 !== 1'b1 || md2 !== 16'hAABB) $display("FAIL bp_hold2: tready=%b valid=%b data=%h want 0/1/aabb", sr2, mv2, md2); else n_pass++;
    mr2 = 1; #1;
    n_chk++; if (sr2 !== 1'b1) $display("FAIL bp_resume_tready: got %b want 1", sr2); else n_pass++;
    step;
    sv2 = 0;
    n_chk++; if (mv2 !== 1'b1 || md2 !== 16'hCCDD) $display("FAIL bp_no_bubble: valid=%b data=%h want 1/ccdd", mv2, md2); else n_pass++;
    step;
    n_chk++; if (mv2 !== 1'b0) $display("FAIL bp_drain: valid=%b want 0", mv2); else n_pass++;
    n_chk++; if (out2.size() != 2 || out2[0] !== 16'hAABB || out2[1] !== 16'hCCDD)
      $display("FAIL bp_sequence: got %0d words want 2 (aabb, ccdd)", out2.size()); else n_pass++;
  endtask

  task automatic test_reset_mid;
    mr4 = 1;
    sv4 = 1; sd4 = 8'h01; step;
    sd4 = 8'h02; step;
    sv4 = 0; rst4 = 1; #1;
    n_chk++; if (sr4 !== 1'b0) $display("FAIL mid_rst_tready: got %b want 0", sr4); else n_pass++;
    step;
    n_chk++; if (sr4 !== 1'b0 || mv4 !== 1'b0) $display("FAIL mid_rst_state: tready=%b valid=%b want 0/0", sr4, mv4); else n_pass++;
    rst4 = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      sv4 = 1; sd4 = 8'(8'hA0 + i);
      step;
      if (i < 3) begin
        n_chk++; if (mv4 !== 1'b0) $display("FAIL mid_partial[%0d]: valid=%b want 0", i, mv4); else n_pass++;
      end
    end
    sv4 = 0;
    n_chk++; if (mv4 !== 1'b1 || md4 !== 32'hA0A1A2A3) $display("FAIL mid_word: valid=%b data=%h want 1/a0a1a2a3", mv4, md4); else n_pass++;
    step;
  endtask

  task automatic test_reset_pending;
    mr2 = 0;
    sv2 = 1; sd2 = 8'h12; step;
    sd2 = 8'h34; step;
    sv2 = 0;
    n_chk++; if (mv2 !== 1'b1 || md2 !== 16'h1234) $display("FAIL pend_word: valid=%b data=%h want 1/1234", mv2, md2); else n_pass++;
    rst2 = 1; step;
    rst2 = 0;
    n_chk++; if (mv2 !== 1'b0) $display("FAIL pend_dropped: valid=%b want 0", mv2); else n_pass++;
    mr2 = 1;
  endtask

  task automatic test_gaps;
    mr2 = 1;
    sv2 = 1; sd2 = 8'h5A; step;
    for (int i = 0; i < 4; i++) begin
      sv2 = 0; sd2 = 8'($urandom);
      step;
      n_chk++; if (mv2 !== 1'b0) $display("FAIL gap_idle[%0d]: valid=%b want 0", i, mv2); else n_pass++;
    end
    sv2 = 1; sd2 = 8'hA5; step;
    sv2 = 0;
    n_chk++; if (mv2 !== 1'b1 || md2 !== 16'h5AA5) $display("FAIL gap_word: valid=%b data=%h want 1/5aa5", mv2, md2); else n_pass++;
    step;
    n_chk++; if (mv2 !== 1'b0) $display("FAIL gap_single: valid=%b want 0", mv2); else n_pass++;
  endtask

  task automatic test_random_w1;
    int unsigned nbad;
    rst1 = 1; sv1 = 0; step; rst1 = 0;
    in1.delete(); out1.delete(); stab1 = 0;
    for (int i = 0; i < 400; i++) begin
      sv1 = ($urandom_range(0, 99) < 70);
      sd1 = 8'($urandom);
      mr1 = ($urandom_range(0, 99) < 60);
      step;
    end
    sv1 = 0; mr1 = 1;
    step; step;
    n_chk++; if (out1.size() != in1.size()) $display("FAIL w1_count: got %0d words want %0d", out1.size(), in1.size()); else n_pass++;
    nbad = 0;
    for (int i = 0; i < out1.size() && i < in1.size(); i++) if (out1[i] !== in1[i]) nbad++;
    n_chk++; if (nbad != 0) $display("FAIL w1_order: got %0d mismatching bytes want 0", nbad); else n_pass++;
    n_chk++; if (stab1 != 0) $display("FAIL w1_stable: got %0d stall violations want 0", stab1); else n_pass++;
  endtask

  task automatic test_random_w3;
    int unsigned nbad;
    logic [23:0] exp;
    rst3 = 1; sv3 = 0; step; rst3 = 0;
    in3.delete(); out3.delete(); stab3 = 0;
    for (int i = 0; i < 600; i++) begin
      sv3 = ($urandom_range(0, 99) < 75);
      sd3 = 8'($urandom);
      mr3 = ($urandom_range(0, 99) < 50);
      step;
    end
    sv3 = 0; mr3 = 1;
    step; step;
    n_chk++; if (out3.size() != in3.size() / 3) $display("FAIL w3_count: got %0d words want %0d", out3.size(), in3.size() / 3); else n_pass++;
    nbad = 0;
    for (int k = 0; k < out3.size() && 3 * k + 2 < in3.size(); k++) begin
      exp = {in3[3*k], in3[3*k+1], in3[3*k+2]};
      if (out3[k] !== exp) nbad++;
    end
    n_chk++; if (nbad != 0) $display("FAIL w3_words: got %0d mismatching words want 0", nbad); else n_pass++;
    n_chk++; if (stab3 != 0) $display("FAIL w3_stable: got %0d stall violations want 0", stab3); else n_pass++;
  endtask

  initial begin
    rst1 = 1; rst2 = 1; rst3 = 1; rst4 = 1;
    sv1 = 0; sv2 = 0; sv3 = 0; sv4 = 0;
    sd1 = '0; sd2 = '0; sd3 = '0; sd4 = '0;
    mr1 = 0; mr2 = 0; mr3 = 0; mr4 = 0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_throughput;
    test_backpressure;
    test_reset_mid;
    test_reset_pending;
    test_gaps;
    test_random_w1;
    test_random_w3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/axis_byte_packer.md
# axis_byte_packer

Byte-to-word AXI-Stream up-converter that sits directly upstream of `axis_processor`. It collects a stream of 8-bit bytes from the host-side link and emits one processor-width word (`PROC_WIDTH_BYTES` bytes) per group of bytes. The first byte received becomes the most significant byte of the word. It sustains one byte per cycle under continuous flow, and applies backpressure only when a completed word cannot yet be handed off.

## Interface

Parameters:
- `WIDTH_BYTES`, default 1: output word width in bytes. Instantiated with `processor_config::PROC_WIDTH_BYTES`. Legal range is ≥1.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: reset. Synchronous and active-high.
- `s_axis_tdata`  in  8: input byte.
- `s_axis_tvalid`  in  1: input byte valid.
- `s_axis_tready`  out  1: block can accept the byte.
- `m_axis_tdata`  out  8*WIDTH_BYTES: packed word. Byte 0 received sits in bits [8*WIDTH_BYTES-1 : 8*WIDTH_BYTES-8].
- `m_axis_tvalid`  out  1: packed word valid.
- `m_axis_tready`  in  1: downstream accepts the word.

## Operation

State:
- Accumulator `acc`: (WIDTH_BYTES-1) bytes. Not present when WIDTH_BYTES=1.
- Byte counter `cnt`: 0..WIDTH_BYTES-1. Width is max(1, $clog2(WIDTH_BYTES)).
- Output register: holds `m_axis_tdata` and `m_axis_tvalid`.

Input handshake:
- An input transfer occurs when `s_axis_tvalid && s_axis_tready`.
- `s_axis_tready` = !rst && ( cnt < WIDTH_BYTES-1 || !m_axis_tvalid || m_axis_tready ).
- Non-final bytes are always accepted, because they go to `acc`, not to the output register.

On a non-final byte (cnt < WIDTH_BYTES-1):
- Shift the byte into `acc` (shift left by 8, new byte in the LSB).
- cnt <= cnt+1.

On the final byte (cnt == WIDTH_BYTES-1):
- m_axis_tdata <= {acc, byte}.
- m_axis_tvalid <= 1.
- cnt <= 0.
- `acc` is not required to be cleared.

Output handshake:
- A word is accepted when `m_axis_tvalid && m_axis_tready`.
- If no final byte arrives in that cycle, m_axis_tvalid <= 0.
- Simultaneous final byte and output accept: load the new word, and m_axis_tvalid stays 1. There is no bubble.
- While m_axis_tvalid=1 and m_axis_tready=0, `m_axis_tdata` is held stable (AXI rule).

Master behaviour:
- `m_axis_tvalid` never depends combinationally on any input.
- `m_axis_tvalid` never drops without a handshake.

WIDTH_BYTES=1:
- Every byte is final. The block degenerates to a single full-throughput register slice.

## Timing

Reset values, applied on the rising edge with rst=1:
- cnt=0, acc=0.
- m_axis_tvalid=0, m_axis_tdata=0.
- `s_axis_tready` is 0 while rst=1, and 1 in the first cycle after rst deasserts.

Latency and throughput:
- Latency is 1 cycle: the word is valid in the cycle after the final byte's handshake edge.
- Throughput is 1 byte/cycle sustained with m_axis_tready=1, i.e. one word every WIDTH_BYTES cycles.

Boundary conditions:
- Backpressure: `s_axis_tready` drops only when cnt==WIDTH_BYTES-1 && m_axis_tvalid && !m_axis_tready.
  - While stalled, cnt and acc hold.
  - Acceptance resumes in the same cycle that m_axis_tready rises.
- Reset mid-word: partial bytes are discarded, and cnt returns to 0.
- Reset with a pending output: the word is dropped and m_axis_tvalid=0. No partial word is ever emitted.
- `s_axis_tdata` is ignored when `s_axis_tvalid`=0.
- Bubbles on the input (gaps in `s_axis_tvalid`) do not alter cnt.

## Test plan

- **Basic packing:** WIDTH_BYTES=3; send 0x11, 0x22, 0x33 back-to-back with m_axis_tready=1.
  - `m_axis_tdata`=0x112233 with m_axis_tvalid=1 for exactly 1 cycle, starting the cycle after 0x33 is accepted.
- **Full throughput:** WIDTH_BYTES=3; send 9 consecutive bytes 0x01..0x09 with tready held high.
  - Words 0x010203, 0x040506, 0x070809.
  - `s_axis_tready` never deasserts.
  - Words arrive 3 cycles apart.
- **Backpressure:** WIDTH_BYTES=2; send 0xAA, 0xBB, 0xCC, 0xDD with m_axis_tready=0.
  - 0xAABB is held stable.
  - 0xCC is accepted.
  - `s_axis_tready`=0 while 0xDD is presented.
  - Raise m_axis_tready: 0xDD is accepted that cycle, and 0xCCDD follows with no bubble.
- **Reset mid-word:** WIDTH_BYTES=4; send 0x01, 0x02, pulse rst for 1 cycle, then send 0xA0..0xA3.
  - Only 0xA0A1A2A3 is emitted.
  - m_axis_tvalid=0 and `s_axis_tready`=0 during reset.
- **Input gaps:** WIDTH_BYTES=2; send 0x5A, then 4 idle cycles, then 0xA5.
  - Exactly one word, 0x5AA5, with no output before the second byte.
- **WIDTH_BYTES=1:** random bytes with random tvalid/tready.
  - Output sequence equals input sequence.
  - `m_axis_tdata` is stable while stalled.
  - No loss or duplication.
